// File: rtl/cr_kme_kdf_pkg.sv
// Shared types and helpers for the KDF slot merger: slot source encoding,
// beat-ratio and counter-width helpers, and per-slot select field extraction.
package cr_kme_kdf_pkg;

    typedef enum logic [1:0] {
        KEY  = 2'd0,
        TAG  = 2'd1,
        GATE = 2'd2,
        ZERO = 2'd3
    } kdf_slot_src_e;

    // Widest select vector the extraction helper accepts; narrower vectors are zero-extended.
    localparam int KDF_MAX_SLOTS = 32;

    function automatic int kdf_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    function automatic int kdf_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic kdf_slot_src_e kdf_slot_sel(input logic [2*KDF_MAX_SLOTS-1:0] src_vec,
                                                   input int idx);
        return kdf_slot_src_e'(src_vec[2*idx +: 2]);
    endfunction

endpackage

// File: rtl/cr_kme_kdf_slot_merger_if.sv
// Bundle of the merger's command, SHA tag, key FIFO and key builder signals.
// slave = merger side, master = surrounding pipeline side.
interface cr_kme_kdf_slot_merger_if #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 64,
    parameter int NUM_SLOTS = 6
);
    logic                   cmdfifo_kdf_valid;
    logic [2*NUM_SLOTS-1:0] cmdfifo_kdf_slot_src;
    logic                   kdf_cmdfifo_ack;
    logic [IN_W-1:0]        sha_tag_data;
    logic                   sha_tag_valid;
    logic                   sha_tag_last;
    logic                   sha_tag_stall;
    logic [IN_W-1:0]        keyfifo_merger_data;
    logic                   keyfifo_merger_valid;
    logic                   merger_keyfifo_ack;
    logic [OUT_W-1:0]       kdf_keybuilder_data;
    logic                   kdf_keybuilder_valid;
    logic                   keybuilder_kdf_stall;
    logic                   kdf_merger_err;

    modport slave (
        input  cmdfifo_kdf_valid, cmdfifo_kdf_slot_src,
        input  sha_tag_data, sha_tag_valid, sha_tag_last,
        input  keyfifo_merger_data, keyfifo_merger_valid,
        input  keybuilder_kdf_stall,
        output kdf_cmdfifo_ack, sha_tag_stall, merger_keyfifo_ack,
        output kdf_keybuilder_data, kdf_keybuilder_valid, kdf_merger_err
    );

    modport master (
        output cmdfifo_kdf_valid, cmdfifo_kdf_slot_src,
        output sha_tag_data, sha_tag_valid, sha_tag_last,
        output keyfifo_merger_data, keyfifo_merger_valid,
        output keybuilder_kdf_stall,
        input  kdf_cmdfifo_ack, sha_tag_stall, merger_keyfifo_ack,
        input  kdf_keybuilder_data, kdf_keybuilder_valid, kdf_merger_err
    );
endinterface

// File: rtl/cr_kme_kdf_downsizer.sv
// Slot buffer of FIFO_DEPTH entries feeding an MSB-first IN_W -> OUT_W beat splitter.
// o_stall reflects occupancy only, so a pop in the same cycle never frees room for a write.
module cr_kme_kdf_downsizer
    import cr_kme_kdf_pkg::*;
#(
    parameter int IN_W       = 128,
    parameter int OUT_W      = 64,
    parameter int FIFO_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [IN_W-1:0]  i_data,
    output logic             o_stall,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    input  logic             i_stall
);
    localparam int R      = kdf_ratio(IN_W, OUT_W);
    localparam int PTR_W  = kdf_cnt_w(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = kdf_cnt_w(R);

    logic [IN_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [BEAT_W-1:0] r_beat;
    logic              w_nonempty;
    logic              w_last_beat;
    logic              w_pop;
    logic [IN_W-1:0]   w_head_shift;

    assign w_nonempty   = (r_count != '0);
    assign o_stall      = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_valid      = w_nonempty & ~i_stall;
    assign w_last_beat  = (r_beat == BEAT_W'(R - 1));
    assign w_pop        = o_valid & w_last_beat;
    assign w_head_shift = r_mem[r_rd_ptr] << (int'(r_beat) * OUT_W);
    // Zero while empty so the bus is quiet out of reset.
    assign o_data       = w_nonempty ? w_head_shift[IN_W-1 -: OUT_W] : '0;

    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_beat   <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (i_wr & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (~i_wr & w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (o_valid) begin
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cr_kme_kdf_slot_merger.sv
// KDF slot merger: builds NUM_SLOTS slots per command from key FIFO / SHA tag / zero
// and streams them out as OUT_W beats. Define CR_KME_KDF_MERGER_ERR_EN for the tag_last checker.
module cr_kme_kdf_slot_merger
    import cr_kme_kdf_pkg::*;
#(
    parameter int IN_W       = 128,
    parameter int OUT_W      = 64,
    parameter int NUM_SLOTS  = 6,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    cr_kme_kdf_slot_merger_if.slave  kdf_bus
);
    localparam int SLOT_W = kdf_cnt_w(NUM_SLOTS);

    logic [SLOT_W-1:0]          r_slot_cnt;
    logic [2*KDF_MAX_SLOTS-1:0] w_src_vec;
    kdf_slot_src_e              w_src;
    logic                       w_is_tag;
    logic                       w_fifo_stall;
    logic                       w_wr;
    logic                       w_last_slot;
    logic [IN_W-1:0]            w_wr_data;

    always_comb begin
        w_src_vec                  = '0;
        w_src_vec[2*NUM_SLOTS-1:0] = kdf_bus.cmdfifo_kdf_slot_src;
    end

    assign w_src       = kdf_slot_sel(w_src_vec, int'(r_slot_cnt));
    assign w_is_tag    = (w_src == TAG) | (w_src == GATE);
    assign w_last_slot = (r_slot_cnt == SLOT_W'(NUM_SLOTS - 1));
    // Every slot consumes a key beat; TAG/GATE slots additionally need a tag, so
    // a tag is never taken without its key.
    assign w_wr = kdf_bus.cmdfifo_kdf_valid & kdf_bus.keyfifo_merger_valid & ~w_fifo_stall
                & (~w_is_tag | kdf_bus.sha_tag_valid);

    always_comb begin
        w_wr_data = kdf_bus.keyfifo_merger_data;
        if (w_src == TAG) begin
            w_wr_data = kdf_bus.sha_tag_data;
        end else if (w_src == ZERO) begin
            w_wr_data = '0;
        end
    end

    assign kdf_bus.merger_keyfifo_ack = w_wr;
    assign kdf_bus.sha_tag_stall      = ~(w_wr & w_is_tag);
    assign kdf_bus.kdf_cmdfifo_ack    = w_wr & w_last_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
        end else if (w_wr) begin
            r_slot_cnt <= w_last_slot ? '0 : r_slot_cnt + 1'b1;
        end
    end

    cr_kme_kdf_downsizer #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_downsizer (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr),
        .i_data  (w_wr_data),
        .o_stall (w_fifo_stall),
        .o_valid (kdf_bus.kdf_keybuilder_valid),
        .o_data  (kdf_bus.kdf_keybuilder_data),
        .i_stall (kdf_bus.keybuilder_kdf_stall)
    );

`ifdef CR_KME_KDF_MERGER_ERR_EN
    logic [NUM_SLOTS-1:0] w_tag_slot;
    logic                 w_later_tag;
    logic                 w_err_hit;
    logic                 r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_tag_slot
            assign w_tag_slot[gi] = (kdf_slot_sel(w_src_vec, gi) == TAG)
                                  | (kdf_slot_sel(w_src_vec, gi) == GATE);
        end
    endgenerate

    // tag_last must be set exactly on the last tag-consuming slot of the command.
    assign w_later_tag = |(w_tag_slot >> (int'(r_slot_cnt) + 1));
    assign w_err_hit   = w_wr & w_is_tag & (kdf_bus.sha_tag_last == w_later_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_hit) begin
            r_err <= 1'b1;
        end
    end

    assign kdf_bus.kdf_merger_err = r_err;
`else
    logic w_unused_tag_last;
    assign w_unused_tag_last      = kdf_bus.sha_tag_last;
    assign kdf_bus.kdf_merger_err = 1'b0;
`endif

endmodule

// File: tb/tb_cr_kme_kdf_slot_merger.sv
// Self-checking bench for cr_kme_kdf_slot_merger: queue-based source models and a
// slot/beat scoreboard derived from the per-command slot sources.
module tb_cr_kme_kdf_slot_merger;
    import cr_kme_kdf_pkg::*;

    localparam int IN_W       = 128;
    localparam int OUT_W      = 64;
    localparam int NUM_SLOTS  = 6;
    localparam int FIFO_DEPTH = 3;
    localparam int R          = IN_W / OUT_W;
`ifdef CR_KME_KDF_MERGER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [IN_W-1:0] data;
        logic            last;
    } tag_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cr_kme_kdf_slot_merger_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_SLOTS(NUM_SLOTS)) bus ();

    cr_kme_kdf_slot_merger #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_SLOTS(NUM_SLOTS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .kdf_bus (bus)
    );

    always #5 clk = ~clk;

    logic [2*NUM_SLOTS-1:0] cmd_q [$];
    logic [IN_W-1:0]        key_q [$];
    tag_t                   tag_q [$];
    logic [OUT_W-1:0]       beat_q[$];

    int checks = 0;
    int errors = 0;
    int m_slot = 0;
    int m_fifo = 0;
    int m_beat = 0;
    bit m_err  = 1'b0;
    int key_pct = 100, tag_pct = 100, stall_pct = 0;
    bit force_stall = 1'b0;
    int n_key_acks = 0, n_tag_pops = 0, n_cmd_acks = 0, n_beats = 0;

    task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_tag_src(input logic [1:0] s);
        return (s == 2'(TAG)) || (s == 2'(GATE));
    endfunction

    function automatic logic [2*NUM_SLOTS-1:0] mk_src(input kdf_slot_src_e s0, s1, s2, s3, s4, s5);
        return {s5, s4, s3, s2, s1, s0};
    endfunction

    // Queue one command with its key beats, tag beats and the expected output beats.
    task automatic push_cmd(input logic [2*NUM_SLOTS-1:0] src, input bit patterned, input bit early_last);
        int first_tag = -1;
        int last_tag  = -1;
        logic [IN_W-1:0] key, tagv, slot;
        logic [1:0] sel;
        tag_t t;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (is_tag_src(src[2*s +: 2])) begin
                last_tag = s;
                if (first_tag < 0) first_tag = s;
            end
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            sel  = src[2*s +: 2];
            key  = patterned ? {64'hA0 + 64'(s), 64'hB0 + 64'(s)} : {$urandom, $urandom, $urandom, $urandom};
            tagv = patterned ? {64'hC0 + 64'(s), 64'hD0 + 64'(s)} : {$urandom, $urandom, $urandom, $urandom};
            key_q.push_back(key);
            slot = key;
            if (sel == 2'(ZERO)) slot = '0;
            if (is_tag_src(sel)) begin
                t.data = tagv;
                t.last = early_last ? (s == first_tag) : (s == last_tag);
                tag_q.push_back(t);
                if (sel == 2'(TAG)) slot = tagv;
            end
            for (int b = 0; b < R; b++) beat_q.push_back(slot[IN_W-1-b*OUT_W -: OUT_W]);
        end
        cmd_q.push_back(src);
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the model.
    task automatic step();
        logic [2*NUM_SLOTS-1:0] src;
        logic [1:0] sel;
        bit cmd_v, key_v, tag_v, stall, is_tag, exp_wr, exp_valid, exp_pop, later, err_next;
        @(negedge clk);
        cmd_v = (cmd_q.size() > 0);
        key_v = (key_q.size() > 0) && ($urandom_range(99) < key_pct);
        tag_v = (tag_q.size() > 0) && ($urandom_range(99) < tag_pct);
        stall = force_stall || ($urandom_range(99) < stall_pct);
        bus.cmdfifo_kdf_valid    = cmd_v;
        bus.cmdfifo_kdf_slot_src = cmd_v ? cmd_q[0] : 12'($urandom);
        bus.keyfifo_merger_valid = key_v;
        bus.keyfifo_merger_data  = key_v ? key_q[0] : {$urandom, $urandom, $urandom, $urandom};
        bus.sha_tag_valid        = tag_v;
        bus.sha_tag_data         = tag_v ? tag_q[0].data : {$urandom, $urandom, $urandom, $urandom};
        bus.sha_tag_last         = tag_v ? tag_q[0].last : 1'($urandom);
        bus.keybuilder_kdf_stall = stall;
        #1;
        src       = cmd_v ? cmd_q[0] : '0;
        sel       = src[2*m_slot +: 2];
        is_tag    = cmd_v && is_tag_src(sel);
        exp_wr    = cmd_v && key_v && (m_fifo < FIFO_DEPTH) && (!is_tag || tag_v);
        exp_valid = (m_fifo > 0) && !stall;
        exp_pop   = exp_valid && (m_beat == R - 1);
        check("key_ack",   bus.merger_keyfifo_ack,   exp_wr);
        check("tag_stall", bus.sha_tag_stall,        !(exp_wr && is_tag));
        check("cmd_ack",   bus.kdf_cmdfifo_ack,      exp_wr && (m_slot == NUM_SLOTS - 1));
        check("kb_valid",  bus.kdf_keybuilder_valid, exp_valid);
        check("err",       bus.kdf_merger_err,       m_err);
        if (exp_valid) check("kb_data", bus.kdf_keybuilder_data, (beat_q.size() > 0) ? beat_q[0] : '0);
        if (bus.merger_keyfifo_ack) n_key_acks++;
        if (!bus.sha_tag_stall) n_tag_pops++;
        if (bus.kdf_cmdfifo_ack) n_cmd_acks++;
        if (bus.kdf_keybuilder_valid) n_beats++;
        err_next = 1'b0;
        if (exp_wr) begin
            if (ERR_EN && is_tag) begin
                later = 1'b0;
                for (int j = m_slot + 1; j < NUM_SLOTS; j++) if (is_tag_src(src[2*j +: 2])) later = 1'b1;
                if (tag_q[0].last == later) err_next = 1'b1;
            end
            void'(key_q.pop_front());
            if (is_tag) void'(tag_q.pop_front());
            if (m_slot == NUM_SLOTS - 1) begin
                m_slot = 0;
                void'(cmd_q.pop_front());
                $display("cmd %0d acked at %0t", n_cmd_acks, $time);
            end else begin
                m_slot++;
            end
        end
        if (exp_valid) begin
            if (beat_q.size() > 0) void'(beat_q.pop_front());
            m_beat = (m_beat == R - 1) ? 0 : m_beat + 1;
        end
        m_fifo = m_fifo + int'(exp_wr) - int'(exp_pop);
        m_err  = m_err | err_next;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((cmd_q.size() > 0 || beat_q.size() > 0 || m_fifo > 0) && n < 2000) begin
            step();
            n++;
        end
        check({name, "_drained"}, n < 2000, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cmdfifo_kdf_valid    = 1'b0;
        bus.cmdfifo_kdf_slot_src = '0;
        bus.keyfifo_merger_valid = 1'b0;
        bus.keyfifo_merger_data  = '0;
        bus.sha_tag_valid        = 1'b0;
        bus.sha_tag_data         = '0;
        bus.sha_tag_last         = 1'b0;
        bus.keybuilder_kdf_stall = 1'b0;
        #1;
        check("rst_kb_valid",  bus.kdf_keybuilder_valid, 1'b0);
        check("rst_kb_data",   bus.kdf_keybuilder_data,  '0);
        check("rst_key_ack",   bus.merger_keyfifo_ack,   1'b0);
        check("rst_cmd_ack",   bus.kdf_cmdfifo_ack,      1'b0);
        check("rst_tag_stall", bus.sha_tag_stall,        1'b1);
        check("rst_err",       bus.kdf_merger_err,       1'b0);
        cmd_q.delete(); key_q.delete(); tag_q.delete(); beat_q.delete();
        m_slot = 0; m_fifo = 0; m_beat = 0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k0, t0, c0, b0, n;
        do_reset();

        // 1: all KEY, patterned keys, no stalls
        c0 = n_cmd_acks; b0 = n_beats;
        push_cmd(mk_src(KEY, KEY, KEY, KEY, KEY, KEY), 1'b1, 1'b0);
        drain("t1");
        check("t1_beats", n_beats - b0, 12);
        check("t1_cmd_acks", n_cmd_acks - c0, 1);

        // 2: all TAG
        k0 = n_key_acks; t0 = n_tag_pops; b0 = n_beats;
        push_cmd(mk_src(TAG, TAG, TAG, TAG, TAG, TAG), 1'b1, 1'b0);
        drain("t2");
        check("t2_key_pops", n_key_acks - k0, 6);
        check("t2_tag_pops", n_tag_pops - t0, 6);
        check("t2_beats", n_beats - b0, 12);

        // 3: mixed sources
        k0 = n_key_acks; t0 = n_tag_pops;
        push_cmd(mk_src(ZERO, GATE, KEY, TAG, ZERO, KEY), 1'b1, 1'b0);
        drain("t3");
        check("t3_key_pops", n_key_acks - k0, 6);
        check("t3_tag_pops", n_tag_pops - t0, 2);

        // 4: key builder stalled for 20 cycles
        k0 = n_key_acks; b0 = n_beats;
        push_cmd(mk_src(TAG, KEY, GATE, TAG, TAG, KEY), 1'b0, 1'b0);
        push_cmd(mk_src(TAG, KEY, GATE, TAG, TAG, KEY), 1'b0, 1'b0);
        force_stall = 1'b1;
        repeat (20) step();
        check("t4_accepted", n_key_acks - k0, FIFO_DEPTH);
        check("t4_tag_stall", bus.sha_tag_stall, 1'b1);
        check("t4_key_ack", bus.merger_keyfifo_ack, 1'b0);
        force_stall = 1'b0;
        drain("t4");
        check("t4_beats", n_beats - b0, 24);

        // 5: reset after slot 3 of a command
        k0 = n_key_acks; c0 = n_cmd_acks; n = 0;
        push_cmd(mk_src(KEY, TAG, KEY, GATE, KEY, ZERO), 1'b0, 1'b0);
        while (n_key_acks - k0 < 4 && n < 100) begin step(); n++; end
        check("t5_reached_slot4", n < 100, 1'b1);
        check("t5_no_cmd_ack", n_cmd_acks - c0, 0);
        do_reset();
        c0 = n_cmd_acks; b0 = n_beats;
        push_cmd(mk_src(KEY, KEY, TAG, KEY, ZERO, GATE), 1'b1, 1'b0);
        drain("t5");
        check("t5_beats", n_beats - b0, 12);
        check("t5_cmd_acks", n_cmd_acks - c0, 1);

        // 6: tag_last on the first of two TAG slots
        push_cmd(mk_src(TAG, TAG, KEY, KEY, KEY, KEY), 1'b0, 1'b1);
        drain("t6");
        repeat (5) step();
        check("t6_err_held", bus.kdf_merger_err, ERR_EN);
        do_reset();

        // Random traffic with gaps and back-pressure
        key_pct = 70; tag_pct = 70; stall_pct = 30;
        b0 = n_beats;
        for (int i = 0; i < 10; i++) push_cmd(12'($urandom), 1'b0, 1'b0);
        drain("rand");
        check("rand_beats", n_beats - b0, 10 * NUM_SLOTS * R);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
